// File: rtl/deser_1to8.sv
// Serial-to-parallel collector: assembles WIDTH bits into a registered word.
// Optional trailing even-parity bit per word when DESER_1TO8_PARITY_EN is defined.
module deser_1to8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             datain,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] dataout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             parity_err
);

`ifdef DESER_1TO8_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] next_shift;
    logic             at_last;
    logic             take;
    logic             complete;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Only the final bit of a word can stall, and only while dataout is unconsumed.
    assign at_last  = (bit_cnt == LAST_CNT);
    assign in_ready = !(at_last && out_valid && !out_ready);
    assign take     = in_valid && in_ready && !sync_clr;
    assign complete = take && at_last;

    // The parity bit position (bit_cnt == WIDTH) matches no lane, so it is not stored.
    always_comb begin
        next_shift = shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == CNT_W'(LSB_FIRST ? i : WIDTH - 1 - i)) begin
                next_shift[i] = datain;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            dataout   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (sync_clr) begin
                bit_cnt <= '0;
            end else if (take) begin
                bit_cnt <= at_last ? '0 : bit_cnt + CNT_W'(1);
            end
            if (take) begin
                shift <= next_shift;
            end
            if (complete) begin
                dataout   <= next_shift;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DESER_1TO8_PARITY_EN
    // At completion shift already holds every data bit; datain is the parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (complete) begin
            parity_err <= (^shift) ^ datain;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_deser_1to8.sv
// Bench for deser_1to8: LSB-first and MSB-first instances share one bit stream;
// a reference model fills expected-word queues that a monitor drains.
module tb_deser_1to8;
    localparam int W = 8;
`ifdef DESER_1TO8_PARITY_EN
    localparam int  LAST_T = W;
    localparam bit  PAR_EN = 1'b1;
`else
    localparam int  LAST_T = W - 1;
    localparam bit  PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sync_clr = 1'b0;
    logic         datain = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready_l, in_ready_m;
    logic [W-1:0] dataout_l, dataout_m;
    logic         out_valid_l, out_valid_m;
    logic         parity_err_l, parity_err_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W:0]   exp_l_q[$];
    logic [W:0]   exp_m_q[$];
    int           out_cyc_q[$];

    int           m_cnt = 0;
    logic [W-1:0] m_l = '0;
    logic [W-1:0] m_m = '0;
    logic         m_par = 1'b0;

    deser_1to8 #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .datain(datain),
        .in_valid(in_valid), .in_ready(in_ready_l), .dataout(dataout_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .parity_err(parity_err_l)
    );

    deser_1to8 #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .datain(datain),
        .in_valid(in_valid), .in_ready(in_ready_m), .dataout(dataout_m),
        .out_valid(out_valid_m), .out_ready(out_ready), .parity_err(parity_err_m)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard: drain then model ----------------
    always @(negedge clk) begin
        logic [W:0] exp;
        if (!rst_n) begin
            exp_l_q.delete();
            exp_m_q.delete();
            m_cnt = 0;
            m_par = 1'b0;
        end else begin
            if (out_valid_l && out_ready) begin
                checks++;
                out_cyc_q.push_back(cyc);
                if (exp_l_q.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_word: unexpected output %h", {parity_err_l, dataout_l});
                end else begin
                    exp = exp_l_q.pop_front();
                    if ({parity_err_l, dataout_l} !== exp) begin
                        errors++;
                        $display("FAIL lsb_word: got %h expected %h", {parity_err_l, dataout_l}, exp);
                    end
                end
            end
            if (out_valid_m && out_ready) begin
                checks++;
                if (exp_m_q.size() == 0) begin
                    errors++;
                    $display("FAIL msb_word: unexpected output %h", {parity_err_m, dataout_m});
                end else begin
                    exp = exp_m_q.pop_front();
                    if ({parity_err_m, dataout_m} !== exp) begin
                        errors++;
                        $display("FAIL msb_word: got %h expected %h", {parity_err_m, dataout_m}, exp);
                    end
                end
            end
            if (sync_clr) begin
                m_cnt = 0;
                m_par = 1'b0;
            end else if (in_valid && in_ready_l) begin
                if (m_cnt < W) begin
                    m_l[m_cnt] = datain;
                    m_m[W-1-m_cnt] = datain;
                end
                m_par = m_par ^ datain;
                if (m_cnt == LAST_T) begin
                    exp_l_q.push_back({m_par & PAR_EN, m_l});
                    exp_m_q.push_back({m_par & PAR_EN, m_m});
                    m_cnt = 0;
                    m_par = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W:0] stream_of(input logic [W-1:0] w, input logic flip);
        return {(^w) ^ flip, w};
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, output int waited);
        in_valid = 1'b1;
        datain   = b;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready_l) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready_l);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input logic [W:0] s, input int n, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < n; i++) begin
            send_bit(s[i], w);
            waits += w;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid_l, parity_err_l, dataout_l} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {out_valid_l, parity_err_l, dataout_l});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b%b required 11", in_ready_l, in_ready_m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsb_stream;
        int waits;
        out_ready = 1'b1;
        send_stream(stream_of(8'h4D, 1'b0), LAST_T + 1, waits);
        in_valid = 1'b0;
        checks++;
        if (out_valid_l !== 1'b1 || dataout_l !== 8'h4D || dataout_m !== 8'hB2 || waits != 0) begin
            errors++;
            $display("FAIL stream_4d: valid %b lsb %h msb %h waits %0d, required 1 4d b2 0",
                     out_valid_l, dataout_l, dataout_m, waits);
        end
        idle(1);
        checks++;
        if (out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL stream_pulse: out_valid %b required 0", out_valid_l);
        end
    endtask

    task automatic test_back_to_back;
        int waits;
        int total = 0;
        out_ready = 1'b1;
        out_cyc_q.delete();
        for (int k = 0; k < 3; k++) begin
            send_stream(stream_of(W'($urandom_range(0, 255)), 1'b0), LAST_T + 1, waits);
            total += waits;
        end
        idle(2);
        checks++;
        if (total != 0) begin
            errors++;
            $display("FAIL b2b_ready: stall cycles %0d required 0", total);
        end
        checks++;
        if (out_cyc_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: words %0d required 3", out_cyc_q.size());
        end else if (out_cyc_q[1] - out_cyc_q[0] != LAST_T + 1 || out_cyc_q[2] - out_cyc_q[1] != LAST_T + 1) begin
            errors++;
            $display("FAIL b2b_spacing: gaps %0d %0d required %0d",
                     out_cyc_q[1] - out_cyc_q[0], out_cyc_q[2] - out_cyc_q[1], LAST_T + 1);
        end
    endtask

    task automatic test_stall;
        int waits;
        out_ready = 1'b0;
        send_stream(stream_of(8'hFF, 1'b0), LAST_T + 1, waits);
        send_stream(stream_of(8'h00, 1'b0), LAST_T, waits);
        checks++;
        if (waits != 0) begin
            errors++;
            $display("FAIL stall_prefix: stall cycles %0d required 0", waits);
        end
        in_valid = 1'b1;
        datain   = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_l !== 1'b0 || out_valid_l !== 1'b1 || dataout_l !== 8'hFF) begin
            errors++;
            $display("FAIL stall_hold: ready %b valid %b data %h required 0 1 ff",
                     in_ready_l, out_valid_l, dataout_l);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready %b required 1", in_ready_l);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid_l !== 1'b1 || dataout_l !== 8'h00 || dataout_m !== 8'h00) begin
            errors++;
            $display("FAIL stall_reload: valid %b lsb %h msb %h required 1 00 00",
                     out_valid_l, dataout_l, dataout_m);
        end
        out_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_sync_clr;
        int waits;
        out_ready = 1'b1;
        send_stream(stream_of(W'($urandom_range(0, 255)), 1'b0), 5, waits);
        in_valid = 1'b1;
        datain   = 1'b1;
        sync_clr = 1'b1;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        send_stream(stream_of(8'hA5, 1'b0), LAST_T + 1, waits);
        in_valid = 1'b0;
        checks++;
        if (out_valid_l !== 1'b1 || dataout_l !== 8'hA5 || dataout_m !== 8'hA5) begin
            errors++;
            $display("FAIL sync_clr_word: valid %b lsb %h msb %h required 1 a5 a5",
                     out_valid_l, dataout_l, dataout_m);
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        int waits;
        logic [W-1:0] r;
        out_ready = 1'b0;
        send_stream(stream_of(W'($urandom_range(1, 255)), 1'b1), LAST_T + 1, waits);
        send_stream(stream_of(W'($urandom_range(0, 255)), 1'b0), 3, waits);
        in_valid = 1'b0;
        checks++;
        if (out_valid_l !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: out_valid %b required 1", out_valid_l);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_l !== 1'b0 || dataout_l !== 8'h00 || dataout_m !== 8'h00 || parity_err_l !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: valid %b lsb %h msb %h perr %b required 0 00 00 0",
                     out_valid_l, dataout_l, dataout_m, parity_err_l);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        r = W'($urandom_range(0, 255));
        send_stream(stream_of(r, 1'b0), LAST_T + 1, waits);
        in_valid = 1'b0;
        checks++;
        if (out_valid_l !== 1'b1 || dataout_l !== r) begin
            errors++;
            $display("FAIL rstmid_word: valid %b data %h required 1 %h", out_valid_l, dataout_l, r);
        end
        idle(1);
    endtask

    task automatic test_parity;
        int waits;
        out_ready = 1'b1;
`ifdef DESER_1TO8_PARITY_EN
        send_stream(stream_of(8'h4D, 1'b0), LAST_T + 1, waits);
        in_valid = 1'b0;
        checks++;
        if (parity_err_l !== 1'b0 || dataout_l !== 8'h4D) begin
            errors++;
            $display("FAIL parity_good: perr %b data %h required 0 4d", parity_err_l, dataout_l);
        end
        send_stream(stream_of(8'h4D, 1'b1), LAST_T + 1, waits);
        in_valid = 1'b0;
        checks++;
        if (parity_err_l !== 1'b1 || dataout_l !== 8'h4D) begin
            errors++;
            $display("FAIL parity_bad: perr %b data %h required 1 4d", parity_err_l, dataout_l);
        end
`else
        send_stream(stream_of(8'h01, 1'b0), LAST_T + 1, waits);
        in_valid = 1'b0;
        checks++;
        if (parity_err_l !== 1'b0 || dataout_l !== 8'h01) begin
            errors++;
            $display("FAIL parity_tied: perr %b data %h required 0 01", parity_err_l, dataout_l);
        end
`endif
        idle(1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lsb_stream();
        test_back_to_back();
        test_stall();
        test_sync_clr();
        test_reset_mid();
        test_parity();
        idle(3);
        checks++;
        if (exp_l_q.size() != 0 || exp_m_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending words %0d %0d required 0 0", exp_l_q.size(), exp_m_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
